// File: rtl/i2s_pfifo_if.sv
// i2s_pfifo_if: sample-port bundle between a FIFO user (master) and the FIFO (slave)
interface i2s_pfifo_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          wen;
  logic [DW-1:0] wdt;
  logic          ren;
  logic [DW-1:0] rdt;
  logic          rvalid;
  logic [AW:0]   level;
  logic [AW:0]   space;
  logic          full;
  logic          empty;
  logic [AW:0]   af_th;
  logic [AW:0]   ae_th;
  logic          afull;
  logic          aempty;
  logic          clr_err;
  logic          ovf;
  logic          udf;
  modport master (
    output wen, wdt, ren, af_th, ae_th, clr_err,
    input  rdt, rvalid, level, space, full, empty, afull, aempty, ovf, udf
  );
  modport slave (
    input  wen, wdt, ren, af_th, ae_th, clr_err,
    output rdt, rvalid, level, space, full, empty, afull, aempty, ovf, udf
  );
endinterface

// File: rtl/i2s_pfifo.sv
// i2s_pfifo: single-clock sample FIFO with FWFT option, level/space, thresholds, sticky ovf/udf
// Ports: clk, rst (async active-high), bus (i2s_pfifo_if.slave: write/read handshake, status, thresholds, errors)
module i2s_pfifo #(
  parameter int DW   = 32,
  parameter int AW   = 4,
  parameter bit FWFT = 1'b0
) (
  input logic        clk,
  input logic        rst,
  i2s_pfifo_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic [DW-1:0] mem [DEPTH];
  logic          full, empty, wa, ra;
  // status decodes from the level register only, so pointer equality never matters
  assign full   = level_q == (AW+1)'(DEPTH);
  assign empty  = level_q == '0;
  assign wa     = bus.wen && !full;
  assign ra     = bus.ren && !empty;
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.level  = level_q;
  assign bus.space  = (AW+1)'(DEPTH) - level_q;
  assign bus.afull  = level_q >= bus.af_th;
  assign bus.aempty = level_q <= bus.ae_th;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;
  always_comb begin
    wp_d    = wa ? wp_q + 1'b1 : wp_q;
    rp_d    = ra ? rp_q + 1'b1 : rp_q;
    level_d = (wa && !ra) ? level_q + 1'b1 : (ra && !wa) ? level_q - 1'b1 : level_q;
    ovf_d   = (bus.wen && full) || (ovf_q && !bus.clr_err);
    udf_d   = (bus.ren && empty) || (udf_q && !bus.clr_err);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  always_ff @(posedge clk)
    if (wa) mem[wp_q] <= bus.wdt;
  if (FWFT) begin : g_fwft
    // head word is presented as soon as it is stored; level reset zeroes rdt asynchronously
    assign bus.rdt    = empty ? '0 : mem[rp_q];
    assign bus.rvalid = !empty;
  end else begin : g_reg
    logic [DW-1:0] rdt_q, rdt_d;
    logic          rvalid_q, rvalid_d;
    always_comb begin
      rdt_d    = ra ? mem[rp_q] : rdt_q;
      rvalid_d = ra;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rdt_q    <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdt_q    <= rdt_d;
        rvalid_q <= rvalid_d;
      end
    assign bus.rdt    = rdt_q;
    assign bus.rvalid = rvalid_q;
  end
endmodule

// File: tb/tb_i2s_pfifo.sv
// tb_i2s_pfifo: queue-model checked bench for registered-read and fall-through FIFO instances
module tb_i2s_pfifo;
  logic        clk = 0;
  logic        rst0 = 1, rst1 = 1;
  logic        wen [2], ren [2], clr [2];
  logic [31:0] wdt [2];
  logic [4:0]  af [2], ae [2];
  logic [31:0] q0 [$], q1 [$];
  logic        eovf [2], eudf [2];
  logic        erv;
  logic [31:0] erd;
  logic        run = 0;
  int          nchk = 0, nerr = 0;
  logic [31:0] exp5 [6];
  i2s_pfifo_if #(.DW(32), .AW(4)) b0 ();
  i2s_pfifo_if #(.DW(32), .AW(4)) b1 ();
  i2s_pfifo #(.DW(32), .AW(4), .FWFT(1'b0)) u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  i2s_pfifo #(.DW(32), .AW(4), .FWFT(1'b1)) u1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  assign b0.wen = wen[0];
  assign b0.ren = ren[0];
  assign b0.wdt = wdt[0];
  assign b0.clr_err = clr[0];
  assign b0.af_th = af[0];
  assign b0.ae_th = ae[0];
  assign b1.wen = wen[1];
  assign b1.ren = ren[1];
  assign b1.wdt = wdt[1];
  assign b1.clr_err = clr[1];
  assign b1.af_th = af[1];
  assign b1.ae_th = ae[1];
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic mreset(input int k);
    if (k == 0) begin
      q0.delete();
      erv = 0;
      erd = 0;
    end else q1.delete();
    eovf[k] = 0;
    eudf[k] = 0;
  endtask
  task automatic mstep();
    bit wa, ra;
    wa = wen[0] && q0.size() < 16;
    ra = ren[0] && q0.size() > 0;
    eovf[0] = (wen[0] && !wa) || (eovf[0] && !clr[0]);
    eudf[0] = (ren[0] && !ra) || (eudf[0] && !clr[0]);
    erv = ra;
    if (ra) erd = q0.pop_front();
    if (wa) q0.push_back(wdt[0]);
    wa = wen[1] && q1.size() < 16;
    ra = ren[1] && q1.size() > 0;
    eovf[1] = (wen[1] && !wa) || (eovf[1] && !clr[1]);
    eudf[1] = (ren[1] && !ra) || (eudf[1] && !clr[1]);
    if (ra) void'(q1.pop_front());
    if (wa) q1.push_back(wdt[1]);
  endtask
  task automatic cyc(input int k, input bit w, input logic [31:0] d, input bit r, input bit c);
    wen[k] = w;
    wdt[k] = d;
    ren[k] = r;
    clr[k] = c;
    @(posedge clk);
    mstep();
    #1;
    for (int i = 0; i < 2; i++) begin
      wen[i] = 0;
      ren[i] = 0;
      clr[i] = 0;
    end
  endtask
  always @(negedge clk) if (run) begin
    chk("level0", 32'(b0.level), q0.size());
    chk("space0", 32'(b0.space), 16 - q0.size());
    chk("full0", 32'(b0.full), 32'(q0.size() == 16));
    chk("empty0", 32'(b0.empty), 32'(q0.size() == 0));
    chk("afull0", 32'(b0.afull), 32'(q0.size() >= int'(af[0])));
    chk("aempty0", 32'(b0.aempty), 32'(q0.size() <= int'(ae[0])));
    chk("ovf0", 32'(b0.ovf), 32'(eovf[0]));
    chk("udf0", 32'(b0.udf), 32'(eudf[0]));
    chk("rvalid0", 32'(b0.rvalid), 32'(erv));
    chk("rdt0", b0.rdt, erd);
    chk("level1", 32'(b1.level), q1.size());
    chk("empty1", 32'(b1.empty), 32'(q1.size() == 0));
    chk("ovf1", 32'(b1.ovf), 32'(eovf[1]));
    chk("udf1", 32'(b1.udf), 32'(eudf[1]));
    chk("rvalid1", 32'(b1.rvalid), 32'(q1.size() > 0));
    chk("rdt1", b1.rdt, q1.size() > 0 ? q1[0] : 32'h0);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      wen[i] = 0;
      ren[i] = 0;
      clr[i] = 0;
      wdt[i] = 0;
      mreset(i);
    end
    af[0] = 12;
    ae[0] = 3;
    af[1] = 16;
    ae[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(b0.level), 0);
    chk("rst_space", 32'(b0.space), 16);
    chk("rst_empty", 32'(b0.empty), 1);
    chk("rst_full", 32'(b0.full), 0);
    chk("rst_rvalid", 32'(b0.rvalid), 0);
    chk("rst_rdt", b0.rdt, 0);
    rst0 = 0;
    rst1 = 0;
    run = 1;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 32'h100 + i, 0, 0);
      if (i == 2) chk("aempty_l3", 32'(b0.aempty), 1);
      if (i == 3) chk("aempty_l4", 32'(b0.aempty), 0);
      if (i == 10) chk("afull_l11", 32'(b0.afull), 0);
      if (i == 11) chk("afull_l12", 32'(b0.afull), 1);
    end
    cyc(0, 1, 32'hDEAD, 0, 0);
    chk("ovf_full", 32'(b0.full), 1);
    chk("ovf_level", 32'(b0.level), 16);
    chk("ovf_flag", 32'(b0.ovf), 1);
    cyc(0, 1, 32'hBEEF, 1, 0);
    chk("both_full_level", 32'(b0.level), 15);
    chk("both_full_rdt", b0.rdt, 32'h100);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("drain_rdt", b0.rdt, 32'h100 + i);
      chk("drain_rvalid", 32'(b0.rvalid), 1);
    end
    chk("drain_empty", 32'(b0.empty), 1);
    cyc(0, 0, 0, 0, 0);
    chk("rvalid_pulse", 32'(b0.rvalid), 0);
    chk("rdt_hold", b0.rdt, 32'h10F);
    cyc(0, 1, 32'h55, 1, 0);
    chk("both_empty_level", 32'(b0.level), 1);
    chk("both_empty_udf", 32'(b0.udf), 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(b0.ovf), 0);
    chk("clr_udf", 32'(b0.udf), 0);
    cyc(0, 0, 0, 1, 0);
    chk("rd55", b0.rdt, 32'h55);
    cyc(0, 0, 0, 1, 1);
    chk("clr_vs_set", 32'(b0.udf), 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 32'h200 + i, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("wrap_a", b0.rdt, 32'h200 + i);
    end
    for (int i = 0; i < 12; i++) cyc(0, 1, 32'h300 + i, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("wrap_b", b0.rdt, 32'h300 + i);
    end
    chk("wrap_level", 32'(b0.level), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h400 + i, 0, 0);
    cyc(0, 1, 32'h4AA, 1, 0);
    chk("both_mid_level", 32'(b0.level), 5);
    exp5 = '{32'h400, 32'h401, 32'h402, 32'h403, 32'h404, 32'h4AA};
    chk("both_mid_rdt", b0.rdt, exp5[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("mid_drain", b0.rdt, exp5[i]);
    end
    cyc(1, 1, 32'hA5, 0, 0);
    chk("fwft_rdt", b1.rdt, 32'hA5);
    chk("fwft_rvalid", 32'(b1.rvalid), 1);
    cyc(1, 0, 0, 1, 0);
    chk("fwft_pop_rdt", b1.rdt, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 32'hB0 + i, 0, 0);
    chk("fwft_head", b1.rdt, 32'hB0);
    chk("fwft_l7", 32'(b1.level), 7);
    #1 rst1 = 1;
    #1;
    chk("arst_level", 32'(b1.level), 0);
    chk("arst_empty", 32'(b1.empty), 1);
    chk("arst_rdt", b1.rdt, 0);
    chk("arst_rvalid", 32'(b1.rvalid), 0);
    mreset(1);
    @(negedge clk);
    rst1 = 0;
    cyc(1, 1, 32'hC1, 0, 0);
    chk("post_rst_wr", b1.rdt, 32'hC1);
    chk("post_rst_ovf", 32'(b1.ovf), 0);
    @(negedge clk);
    #1;
    run = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
